alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that lets up to NUM_REQ requesters share one combinational 32-bit ALU (AND/OR/NOR/ADD/SUB/SLT slice set).
- Accepts one operation at a time, registers the operands, drives the shared ALU for one cycle, registers its result, and returns it to the granted requester over a valid/ready response handshake.
- Sits between the datapath control and the shared ALU instance in the multi-cycle build.

Parameters:
- NUM_REQ, 2, number of requesters; legal 2..4.
- WIDTH, 32, operand/result width.
- OPW, 3, ALU control width; passed through uninterpreted.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_op  in  OPW*NUM_REQ  ALU control, requester i at [OPW*i +: OPW].
- req_a  in  WIDTH*NUM_REQ  operand A, requester i at [WIDTH*i +: WIDTH].
- req_b  in  WIDTH*NUM_REQ  operand B, same packing.
- resp_valid  out  NUM_REQ  one-hot result valid to the owning requester.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_result  out  WIDTH  registered ALU result (shared bus).
- resp_zero  out  1  registered ALU zero flag.
- alu_op  out  OPW  control to shared ALU.
- alu_a  out  WIDTH  operand A to shared ALU.
- alu_b  out  WIDTH  operand B to shared ALU.
- alu_result  in  WIDTH  combinational result from shared ALU.
- alu_zero  in  1  combinational zero flag from shared ALU.

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high.
- FSM states: IDLE, EXEC, RESP.
- Reset (synchronous, active-high, also mid-operation): state=IDLE; rr_ptr=0; owner=0; resp_valid=0; resp_result=0; resp_zero=0; alu_op/alu_a/alu_b registers=0; any in-flight operation is dropped with no response.
- IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set index g gets req_ready[g]=1 combinationally; all other ready bits are 0.
  - If no valid bit is set, req_ready=0 and the FSM stays in IDLE.
  - On handshake (valid&ready at edge T): latch op/a/b of g into the alu_* registers, owner=g, rr_ptr=(g+1) mod NUM_REQ, go to EXEC.
- EXEC (cycle T+1):
  - alu_* hold the latched operands.
  - At the edge, capture alu_result into resp_result and alu_zero into resp_zero, then go to RESP.
- RESP (from T+2):
  - resp_valid[owner]=1; resp_result and resp_zero are held stable.
  - Stay in RESP until resp_ready[owner]=1.
  - On that edge, clear resp_valid and go to IDLE.
  - resp_ready bits of non-owners are ignored.
- Latency and throughput: request accept to resp_valid is 2 cycles. Minimum spacing between accepts is 3 cycles; there is no accept in the cycle the response completes.
- req_ready is 0 outside IDLE. Requesters hold valid and operands stable until accepted. Deasserting valid before acceptance withdraws the request harmlessly.
- Fairness: a requester continuously asserting valid is granted within NUM_REQ grants.
- Simultaneous requests: the lowest index at or after rr_ptr wins.
- Wrap-around: rr_ptr at NUM_REQ-1 advances to 0.
- alu_* outputs are registers: stable through EXEC and RESP, and changed only on accept.
- Width rules: no arithmetic inside this block; op, operands and results are passed bit-exact. The zero flag comes from the ALU, not recomputed.

Decomposition:
- Shared package holds:
  - FSM state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
  - ALU control constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_NOR=3'b100, ALU_SUB=3'b110, ALU_SLT=3'b111, used by benches and control.
- One natural sub-module: rr_pick. It is combinational and takes req_valid and rr_ptr, returning a one-hot grant plus grant index and an any flag.

Test Plan:
- Single request: req 0 with op=ALU_NOR, a=0x0000FFFF, b=0x00FF00FF; ALU model returns 0xFF000000 -> req_ready[0] at T, alu_op=3'b100 in EXEC, resp_valid=2'b01 at T+2, resp_result=0xFF000000, resp_zero=0.
- Contention: both requesters valid continuously from reset with distinct operands (req0 ADD 5+7, req1 SUB 9-9) -> grants alternate 0,1,0,1; results 12 (zero=0) to req0 and 0 (zero=1) to req1.
- Response backpressure: hold resp_ready[0]=0 for 5 cycles after resp_valid -> resp_valid and resp_result=0x0000000C stay stable, req_ready=0 throughout; IDLE follows the cycle after resp_ready rises.
- Wrong-owner ready: owner=1, assert resp_ready=2'b01 -> no completion; then 2'b10 -> completes.
- Reset mid-operation: assert reset during EXEC and separately during RESP -> next cycle resp_valid=0, req_ready grants index 0 (rr_ptr=0), no stale response delivered.
- NUM_REQ=4, only req 3 then req 0 valid -> rr_ptr wraps 3->0; req 0 granted with no idle gap beyond the 3-cycle minimum.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU share arbiter: FSM encoding and ALU control codes.
package alu_share_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_EXEC = ST_EXEC,
        S_RESP = ST_RESP
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module alu_share_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = {1'b0, ptr} + (IW+1)'(k);
            if (j >= (IW+1)'(NUM_REQ)) begin
                j = j - (IW+1)'(NUM_REQ);
            end
            if (!any && valid[j[IW-1:0]]) begin
                any               = 1'b1;
                idx               = j[IW-1:0];
                grant[j[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU among NUM_REQ requesters.
//   state | meaning
//   IDLE  | scan requests from rr_ptr, accept one and latch its operands
//   EXEC  | latched operands drive the ALU; result captured at the edge
//   RESP  | result held for owner until its resp_ready
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int OPW     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [OPW*NUM_REQ-1:0]   req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_result,
    output logic                     resp_zero,
    output logic [OPW-1:0]           alu_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_zero
);

    localparam int IW = $clog2(NUM_REQ);

    state_t             state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      owner;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    alu_share_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Ready is only offered while idle, so a grant is always a handshake.
    assign req_ready = (state == S_IDLE) ? pick_grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            resp_valid  <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        alu_op <= req_op[OPW*pick_idx +: OPW];
                        alu_a  <= req_a[WIDTH*pick_idx +: WIDTH];
                        alu_b  <= req_b[WIDTH*pick_idx +: WIDTH];
                        owner  <= pick_idx;
                        rr_ptr <= (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_result <= alu_result;
                    resp_zero   <= alu_zero;
                    resp_valid  <= NUM_REQ'(1) << owner;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid <= '0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a 2-requester and a 4-requester instance,
// each fed by a behavioural shared ALU.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_NOR: return ~(a | b);
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Two-requester instance
    logic [1:0]  va, ra, rva, rra;
    logic [5:0]  opa;
    logic [63:0] aa, ba;
    logic [31:0] res_a, a_a, b_a, alr_a;
    logic        z_a, alz_a;
    logic [2:0]  aop_a;

    assign alr_a = alu_f(aop_a, a_a, b_a);
    assign alz_a = (alr_a == 32'd0);

    alu_share_arbiter #(.NUM_REQ(2), .WIDTH(32), .OPW(3)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (va),
        .req_ready   (ra),
        .req_op      (opa),
        .req_a       (aa),
        .req_b       (ba),
        .resp_valid  (rva),
        .resp_ready  (rra),
        .resp_result (res_a),
        .resp_zero   (z_a),
        .alu_op      (aop_a),
        .alu_a       (a_a),
        .alu_b       (b_a),
        .alu_result  (alr_a),
        .alu_zero    (alz_a)
    );

    // Four-requester instance
    logic [3:0]   vb, rb, rvb, rrb;
    logic [11:0]  opb;
    logic [127:0] ab, bb;
    logic [31:0]  res_b, a_b, b_b, alr_b;
    logic         z_b, alz_b;
    logic [2:0]   aop_b;

    assign alr_b = alu_f(aop_b, a_b, b_b);
    assign alz_b = (alr_b == 32'd0);

    alu_share_arbiter #(.NUM_REQ(4), .WIDTH(32), .OPW(3)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (vb),
        .req_ready   (rb),
        .req_op      (opb),
        .req_a       (ab),
        .req_b       (bb),
        .resp_valid  (rvb),
        .resp_ready  (rrb),
        .resp_result (res_b),
        .resp_zero   (z_b),
        .alu_op      (aop_b),
        .alu_a       (a_b),
        .alu_b       (b_b),
        .alu_result  (alr_b),
        .alu_zero    (alz_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        va = '0; rra = '0; opa = '0; aa = '0; ba = '0;
        vb = '0; rrb = '0; opb = '0; ab = '0; bb = '0;
        tick;
        tick;
        check("rst_resp_valid", 32'(rva), 32'h0);
        check("rst_result", res_a, 32'h0);
        check("rst_zero", 32'(z_a), 32'h0);
        check("rst_alu_op", 32'(aop_a), 32'h0);
        check("rst_alu_a", a_a, 32'h0);
        check("rst_ready", 32'(ra), 32'h0);
        reset = 1'b0;
        tick;

        // Single NOR request from requester 0
        va  = 2'b01;
        opa = {3'b000, ALU_NOR};
        aa  = {32'h0, 32'h0000FFFF};
        ba  = {32'h0, 32'h00FF00FF};
        rra = 2'b00;
        #1;
        check("single_ready", 32'(ra), 32'h1);
        tick;
        va = 2'b00;
        #1;
        check("single_exec_op", 32'(aop_a), 32'(3'b100));
        check("single_exec_a", a_a, 32'h0000FFFF);
        check("single_exec_ready", 32'(ra), 32'h0);
        check("single_exec_rv", 32'(rva), 32'h0);
        tick;
        check("single_rv", 32'(rva), 32'h1);
        check("single_result", res_a, 32'hFF000000);
        check("single_zero", 32'(z_a), 32'h0);
        rra = 2'b01;
        tick;
        check("single_done_rv", 32'(rva), 32'h0);

        // Contention from reset: both requesters continuously valid
        reset = 1'b1;
        tick;
        reset = 1'b0;
        va  = 2'b11;
        opa = {ALU_SUB, ALU_ADD};
        aa  = {32'd9, 32'd5};
        ba  = {32'd9, 32'd7};
        rra = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_grant", 32'(ra), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick;
            tick;
            check("cont_rv", 32'(rva), (i % 2 == 0) ? 32'h1 : 32'h2);
            check("cont_result", res_a, (i % 2 == 0) ? 32'd12 : 32'd0);
            check("cont_zero", 32'(z_a), (i % 2 == 0) ? 32'h0 : 32'h1);
            tick;
        end

        // Response backpressure on requester 0, requester 1 waiting meanwhile
        va  = 2'b01;
        rra = 2'b00;
        #1;
        check("bp_ready", 32'(ra), 32'h1);
        tick;
        va  = 2'b10;
        opa = {ALU_AND, ALU_ADD};
        aa  = {32'h0000F0F0, 32'd5};
        ba  = {32'h0000FF00, 32'd7};
        tick;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_rv", 32'(rva), 32'h1);
            check("bp_hold_result", res_a, 32'h0000000C);
            check("bp_hold_ready", 32'(ra), 32'h0);
            tick;
        end
        rra = 2'b01;
        #1;
        check("bp_last_rv", 32'(rva), 32'h1);
        tick;
        check("bp_done_rv", 32'(rva), 32'h0);
        check("bp_idle_ready", 32'(ra), 32'h2);

        // Wrong-owner ready: owner is requester 1
        rra = 2'b00;
        tick;
        va = 2'b00;
        tick;
        check("wo_rv", 32'(rva), 32'h2);
        check("wo_result", res_a, 32'h0000F000);
        rra = 2'b01;
        tick;
        check("wo_ignored", 32'(rva), 32'h2);
        rra = 2'b10;
        tick;
        check("wo_done", 32'(rva), 32'h0);

        // Reset during EXEC
        va  = 2'b01;
        rra = 2'b00;
        #1;
        check("rx_ready", 32'(ra), 32'h1);
        tick;
        reset = 1'b1;
        va    = 2'b11;
        tick;
        reset = 1'b0;
        #1;
        check("rx_rv", 32'(rva), 32'h0);
        check("rx_ready_after", 32'(ra), 32'h1);
        check("rx_alu_op", 32'(aop_a), 32'h0);

        // Reset during RESP
        tick;
        tick;
        check("rr_rv_before", 32'(rva), 32'h1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        check("rr_rv", 32'(rva), 32'h0);
        check("rr_ready_after", 32'(ra), 32'h1);
        check("rr_result", res_a, 32'h0);
        va = 2'b00;
        tick;
        tick;
        check("rr_no_stale", 32'(rva), 32'h0);

        // Four requesters: req 3 then req 0, pointer wraps 3 -> 0
        vb  = 4'b1000;
        opb = {ALU_OR, 3'b000, 3'b000, ALU_SLT};
        ab  = {32'h12340000, 64'h0, 32'hFFFFFFFF};
        bb  = {32'h00005678, 64'h0, 32'h00000001};
        rrb = 4'b1111;
        #1;
        check("n4_ready3", 32'(rb), 32'h8);
        tick;
        vb = 4'b0001;
        #1;
        check("n4_exec_ready", 32'(rb), 32'h0);
        check("n4_exec_op", 32'(aop_b), 32'(ALU_OR));
        tick;
        check("n4_rv3", 32'(rvb), 32'h8);
        check("n4_result3", res_b, 32'h12345678);
        tick;
        check("n4_ready0", 32'(rb), 32'h1);
        tick;
        vb = 4'b0000;
        #1;
        check("n4_exec_a0", a_b, 32'hFFFFFFFF);
        check("n4_exec_op0", 32'(aop_b), 32'(ALU_SLT));
        tick;
        check("n4_rv0", 32'(rvb), 32'h1);
        check("n4_result0", res_b, 32'h00000001);
        check("n4_zero0", 32'(z_b), 32'h0);
        tick;
        check("n4_done", 32'(rvb), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
